// File: rtl/branch_npc_unit_if.sv
// Fetch next-PC / prediction-carrier bundle between the pipeline and branch_npc_unit.
interface branch_npc_unit_if #(
    parameter int CNT_W = 32
);
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             FlushE;
    logic             PredF;
    logic [31:0]      NPC_PredF;
    logic             JalD;
    logic [31:0]      JalNPC;
    logic             JalrE;
    logic [31:0]      JalrNPC;
    logic             BranchTypeE;
    logic             BranchE;
    logic [31:0]      BrNPC;
    logic [31:0]      PCE;
    logic [31:0]      PCF;
    logic             PredE;
    logic [31:0]      NPC_PredE;
    logic             MispredE;
    logic [CNT_W-1:0] BrCount;
    logic [CNT_W-1:0] MissCount;

    modport master (
        output StallF, StallD, FlushD, FlushE,
        output PredF, NPC_PredF, JalD, JalNPC,
        output JalrE, JalrNPC, BranchTypeE, BranchE,
        output BrNPC, PCE,
        input  PCF, PredE, NPC_PredE, MispredE,
        input  BrCount, MissCount
    );

    modport slave (
        input  StallF, StallD, FlushD, FlushE,
        input  PredF, NPC_PredF, JalD, JalNPC,
        input  JalrE, JalrNPC, BranchTypeE, BranchE,
        input  BrNPC, PCE,
        output PCF, PredE, NPC_PredE, MispredE,
        output BrCount, MissCount
    );
endinterface

// File: rtl/branch_npc_unit.sv
// Fetch PC register, next-PC select, prediction carry F->D->E,
// EX misprediction resolve and branch statistics.
module branch_npc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input logic             clk,
    input logic             rst,
    branch_npc_unit_if.slave bus
);
    logic [31:0]      pcf_q;
    logic             pred_d;
    logic [31:0]      npc_pred_d;
    logic             pred_e;
    logic [31:0]      npc_pred_e;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] miss_cnt;

    logic        mis_nt;
    logic        mis_t;
    logic        mis_tgt;
    logic        mis_nb;
    logic        mispred;
    logic        redir;
    logic [31:0] fix_npc;
    logic [31:0] npc;

    always_comb begin
        mis_nt  = bus.BranchTypeE & pred_e & ~bus.BranchE;
        mis_t   = bus.BranchTypeE & ~pred_e & bus.BranchE;
        mis_tgt = bus.BranchTypeE & pred_e & bus.BranchE
                & (npc_pred_e != bus.BrNPC);
        // A prediction on a non-branch is a stale BHT alias; fall through.
        mis_nb  = ~bus.BranchTypeE & ~bus.JalrE & pred_e;
        mispred = mis_nt | mis_t | mis_tgt | mis_nb;
        redir   = mispred | bus.JalrE;
        fix_npc = (mis_nt | mis_nb) ? bus.PCE + 32'd4 : bus.BrNPC;
    end

    always_comb begin
        npc = pcf_q + 32'd4;
        if (mispred)
            npc = fix_npc;
        else if (bus.JalrE)
            npc = bus.JalrNPC;
        else if (bus.StallF)
            npc = pcf_q;
        else if (bus.JalD)
            npc = bus.JalNPC;
        else if (bus.PredF)
            npc = bus.NPC_PredF;
    end

    always_ff @(posedge clk) begin
        if (rst)
            pcf_q <= RESET_PC;
        else
            pcf_q <= npc;
    end

    always_ff @(posedge clk) begin
        if (rst || bus.FlushD || redir || (bus.JalD && !bus.StallF)) begin
            pred_d     <= 1'b0;
            npc_pred_d <= '0;
        end else if (!bus.StallD) begin
            pred_d     <= bus.PredF;
            npc_pred_d <= bus.NPC_PredF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.FlushE || redir) begin
            pred_e     <= 1'b0;
            npc_pred_e <= '0;
        end else begin
            pred_e     <= pred_d;
            npc_pred_e <= npc_pred_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt   <= '0;
            miss_cnt <= '0;
        end else begin
            if (bus.BranchTypeE)
                br_cnt <= br_cnt + 1'b1;
            if (mispred)
                miss_cnt <= miss_cnt + 1'b1;
        end
    end

    assign bus.PCF       = pcf_q;
    assign bus.PredE     = pred_e;
    assign bus.NPC_PredE = npc_pred_e;
    assign bus.MispredE  = mispred;
    assign bus.BrCount   = br_cnt;
    assign bus.MissCount = miss_cnt;
endmodule

// File: tb/tb_branch_npc_unit.sv
// Directed bench for branch_npc_unit: next-PC priority, prediction carry,
// misprediction resolve and counters.
module tb_branch_npc_unit;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    branch_npc_unit_if #(.CNT_W(32)) bus ();

    branch_npc_unit #(
        .RESET_PC(32'h0000_0000),
        .CNT_W   (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.StallF = 0; bus.StallD = 0; bus.FlushD = 0; bus.FlushE = 0;
        bus.PredF = 0; bus.NPC_PredF = 0; bus.JalD = 0; bus.JalNPC = 0;
        bus.JalrE = 0; bus.JalrNPC = 0; bus.BranchTypeE = 0;
        bus.BranchE = 0; bus.BrNPC = 0; bus.PCE = 0;

        // reset
        tick(); tick();
        chk("rst_pcf", bus.PCF, 32'h0);
        chk("rst_prede", {31'b0, bus.PredE}, 32'h0);
        chk("rst_brcnt", bus.BrCount, 32'h0);
        chk("rst_misscnt", bus.MissCount, 32'h0);
        rst = 1'b0;
        chk("pc0", bus.PCF, 32'h0);
        tick();
        chk("pc4", bus.PCF, 32'h4);
        tick();
        chk("pc8", bus.PCF, 32'h8);
        tick(); tick();
        chk("pc10", bus.PCF, 32'h10);

        // predicted taken, correct
        bus.PredF = 1; bus.NPC_PredF = 32'h40;
        tick();
        chk("predf_pcf", bus.PCF, 32'h40);
        bus.PredF = 0;
        tick();
        chk("ok_prede", {31'b0, bus.PredE}, 32'h1);
        chk("ok_npce", bus.NPC_PredE, 32'h40);
        bus.BranchTypeE = 1; bus.BranchE = 1;
        bus.BrNPC = 32'h40; bus.PCE = 32'h10;
        #1;
        chk("ok_mispred", {31'b0, bus.MispredE}, 32'h0);
        tick();
        chk("ok_brcnt", bus.BrCount, 32'h1);
        chk("ok_misscnt", bus.MissCount, 32'h0);
        chk("ok_pcf", bus.PCF, 32'h48);
        bus.BranchTypeE = 0;

        // predicted taken, not taken
        bus.PredF = 1; bus.NPC_PredF = 32'h40;
        tick();
        bus.PredF = 0;
        tick();
        bus.BranchTypeE = 1; bus.BranchE = 0; bus.PCE = 32'h10;
        bus.PredF = 1; bus.NPC_PredF = 32'h99;
        #1;
        chk("nt_mispred", {31'b0, bus.MispredE}, 32'h1);
        tick();
        chk("nt_pcf", bus.PCF, 32'h14);
        chk("nt_prede", {31'b0, bus.PredE}, 32'h0);
        chk("nt_misscnt", bus.MissCount, 32'h1);
        chk("nt_brcnt", bus.BrCount, 32'h2);
        bus.BranchTypeE = 0; bus.PredF = 0;
        #1;
        chk("bubble_mispred", {31'b0, bus.MispredE}, 32'h0);
        tick();
        chk("nt_predd_clr", {31'b0, bus.PredE}, 32'h0);
        chk("nt_pcf2", bus.PCF, 32'h18);

        // not predicted, taken, under StallF
        bus.BranchTypeE = 1; bus.BranchE = 1; bus.BrNPC = 32'h80;
        bus.StallF = 1;
        #1;
        chk("t_mispred", {31'b0, bus.MispredE}, 32'h1);
        tick();
        chk("t_pcf", bus.PCF, 32'h80);
        chk("t_brcnt", bus.BrCount, 32'h3);
        chk("t_misscnt", bus.MissCount, 32'h2);
        bus.StallF = 0; bus.BranchTypeE = 0;

        // wrong target
        bus.PredF = 1; bus.NPC_PredF = 32'h40;
        tick();
        bus.PredF = 0;
        tick();
        bus.BranchTypeE = 1; bus.BranchE = 1;
        bus.BrNPC = 32'h44; bus.PCE = 32'h30;
        bus.PredF = 1; bus.NPC_PredF = 32'h100;
        #1;
        chk("wt_mispred", {31'b0, bus.MispredE}, 32'h1);
        tick();
        chk("wt_pcf", bus.PCF, 32'h44);
        chk("wt_misscnt", bus.MissCount, 32'h3);
        chk("wt_brcnt", bus.BrCount, 32'h4);
        bus.BranchTypeE = 0; bus.PredF = 0;

        // JALR beats StallF
        bus.JalrE = 1; bus.JalrNPC = 32'h300; bus.StallF = 1;
        tick();
        chk("jalr_pcf", bus.PCF, 32'h300);
        bus.JalrE = 0; bus.StallF = 0;

        // stale prediction on a non-branch
        bus.PredF = 1; bus.NPC_PredF = 32'h40;
        tick();
        bus.PredF = 0;
        tick();
        bus.PCE = 32'h500;
        #1;
        chk("nb_mispred", {31'b0, bus.MispredE}, 32'h1);
        tick();
        chk("nb_pcf", bus.PCF, 32'h504);
        chk("nb_misscnt", bus.MissCount, 32'h4);

        // JAL beats PredF and clears D
        bus.JalD = 1; bus.JalNPC = 32'h200;
        bus.PredF = 1; bus.NPC_PredF = 32'h40;
        tick();
        chk("jal_pcf", bus.PCF, 32'h200);
        bus.JalD = 0; bus.PredF = 0;
        tick();
        chk("jal_predd_clr", {31'b0, bus.PredE}, 32'h0);

        // JAL under stall: PC and D held
        bus.PredF = 1; bus.NPC_PredF = 32'h40;
        tick();
        chk("st_pcf0", bus.PCF, 32'h40);
        bus.JalD = 1; bus.JalNPC = 32'h200;
        bus.StallF = 1; bus.StallD = 1; bus.FlushE = 1;
        bus.NPC_PredF = 32'h77;
        tick();
        chk("st_pcf", bus.PCF, 32'h40);
        chk("st_prede", {31'b0, bus.PredE}, 32'h0);
        bus.JalD = 0; bus.PredF = 0;
        bus.StallF = 0; bus.StallD = 0; bus.FlushE = 0;
        tick();
        chk("st_predd_held", {31'b0, bus.PredE}, 32'h1);
        chk("st_npcd_held", bus.NPC_PredE, 32'h40);

        // reset during an active redirect
        chk("rr_mispred", {31'b0, bus.MispredE}, 32'h1);
        rst = 1;
        tick();
        rst = 0;
        chk("rr_pcf", bus.PCF, 32'h0);
        chk("rr_prede", {31'b0, bus.PredE}, 32'h0);
        chk("rr_misscnt", bus.MissCount, 32'h0);
        chk("rr_brcnt", bus.BrCount, 32'h0);
        tick();
        chk("rr_pcf4", bus.PCF, 32'h4);

        // PC+4 wraps at the top of the address space
        bus.JalD = 1; bus.JalNPC = 32'hFFFF_FFFC;
        tick();
        chk("wrap_top", bus.PCF, 32'hFFFF_FFFC);
        bus.JalD = 0;
        tick();
        chk("wrap_zero", bus.PCF, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
